// File: rtl/demux8_nbit.sv
// ---------------------------------------------------------------------------
// demux8_nbit
// Routes one N-bit source lane to one of eight destination lanes. The block
// is break-before-make: a newly selected channel is connected only after a
// configurable number of idle "guard" cycles. Unconnected lanes drive the
// recessive IDLE_VAL level.
//
// Parameters
//   N            width of each data lane
//   IDLE_VAL     level driven on every unconnected lane
//   GUARD_CYCLES idle cycles (0..255) inserted before a new channel connects
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous, active-low reset
//   data_in      source lane
//   sel          requested destination channel 0..7
//   sel_valid    connect request, taken when ready=1 and disc=0
//   disc         single-cycle disconnect request (wins over sel_valid)
//   data_out0..7 registered destination lanes
//   ready        registered; 1 when a connect request can be accepted
//   connected    registered; 1 while a channel is passing data
//   active_ch    channel latched by the last accepted request
// ---------------------------------------------------------------------------
module demux8_nbit #(
    parameter int             N            = 2,
    parameter logic [N-1:0]   IDLE_VAL     = {N{1'b1}},
    parameter int             GUARD_CYCLES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] data_in,
    input  logic [2:0]   sel,
    input  logic         sel_valid,
    input  logic         disc,
    output logic [N-1:0] data_out0,
    output logic [N-1:0] data_out1,
    output logic [N-1:0] data_out2,
    output logic [N-1:0] data_out3,
    output logic [N-1:0] data_out4,
    output logic [N-1:0] data_out5,
    output logic [N-1:0] data_out6,
    output logic [N-1:0] data_out7,
    output logic         ready,
    output logic         connected,
    output logic [2:0]   active_ch
);

    localparam logic [7:0] GUARD_LOAD = 8'(GUARD_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GUARD  = 2'd1,
        ST_ACTIVE = 2'd2
    } state_t;

    state_t         state_r;
    state_t         state_nxt_s;
    logic [7:0]     cnt_r;
    logic [7:0]     cnt_nxt_s;
    logic [2:0]     ch_r;
    logic [2:0]     ch_nxt_s;
    logic [N-1:0]   lane_r     [8];
    logic [N-1:0]   lane_nxt_s [8];
    logic           ready_r;
    logic           connected_r;
    logic           accept_s;
    state_t         load_state_s;

    // Next-state, counter, channel latch and lane values
    always_comb begin
        state_nxt_s  = state_r;
        cnt_nxt_s    = cnt_r;
        ch_nxt_s     = ch_r;
        // A request is only taken outside GUARD, and a disconnect on the same
        // edge drops it.
        accept_s     = sel_valid && (state_r != ST_GUARD) && !disc;
        load_state_s = (GUARD_LOAD == 8'd0) ? ST_ACTIVE : ST_GUARD;
        for (int i = 0; i < 8; i++) begin
            lane_nxt_s[i] = IDLE_VAL;
        end

        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    ch_nxt_s    = sel;
                    cnt_nxt_s   = GUARD_LOAD;
                    state_nxt_s = load_state_s;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_GUARD: begin
                if (disc) begin
                    state_nxt_s = ST_IDLE;
                end else if (cnt_r <= 8'd1) begin
                    // A zero count is unreachable here; treating it like 1
                    // keeps the counter from wrapping and the FSM from sticking.
                    cnt_nxt_s   = 8'd0;
                    state_nxt_s = ST_ACTIVE;
                end else begin
                    cnt_nxt_s   = cnt_r - 8'd1;
                end
            end
            ST_ACTIVE: begin
                if (disc) begin
                    state_nxt_s = ST_IDLE;
                end else if (accept_s && (sel != ch_r)) begin
                    // Old lane drops to idle on this edge so the two channels
                    // never overlap.
                    ch_nxt_s    = sel;
                    cnt_nxt_s   = GUARD_LOAD;
                    state_nxt_s = load_state_s;
                end else begin
                    lane_nxt_s[ch_r] = data_in;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = 8'd0;
                ch_nxt_s    = 3'd0;
            end
        endcase
    end

    // State, counter, channel, lane and status registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            cnt_r       <= 8'd0;
            ch_r        <= 3'd0;
            ready_r     <= 1'b1;
            connected_r <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                lane_r[i] <= IDLE_VAL;
            end
        end else begin
            state_r     <= state_nxt_s;
            cnt_r       <= cnt_nxt_s;
            ch_r        <= ch_nxt_s;
            ready_r     <= (state_nxt_s != ST_GUARD);
            connected_r <= (state_nxt_s == ST_ACTIVE);
            for (int i = 0; i < 8; i++) begin
                lane_r[i] <= lane_nxt_s[i];
            end
        end
    end

    assign data_out0 = lane_r[0];
    assign data_out1 = lane_r[1];
    assign data_out2 = lane_r[2];
    assign data_out3 = lane_r[3];
    assign data_out4 = lane_r[4];
    assign data_out5 = lane_r[5];
    assign data_out6 = lane_r[6];
    assign data_out7 = lane_r[7];
    assign ready     = ready_r;
    assign connected = connected_r;
    assign active_ch = ch_r;

endmodule

// ---------------------------------------------------------------------------
// demux8_nbit_chk
// Property checker for demux8_nbit: at most one lane away from IDLE_VAL, and
// never connected while not ready (connected implies not in GUARD).
//
// Ports: clk, rst, ready, connected and the eight data_out lanes of the DUT.
// ---------------------------------------------------------------------------
module demux8_nbit_chk #(
    parameter int           N        = 2,
    parameter logic [N-1:0] IDLE_VAL = {N{1'b1}}
) (
    input logic         clk,
    input logic         rst,
    input logic         ready,
    input logic         connected,
    input logic [N-1:0] data_out0,
    input logic [N-1:0] data_out1,
    input logic [N-1:0] data_out2,
    input logic [N-1:0] data_out3,
    input logic [N-1:0] data_out4,
    input logic [N-1:0] data_out5,
    input logic [N-1:0] data_out6,
    input logic [N-1:0] data_out7
);

    logic [3:0] busy_cnt_s;

    // Count lanes that are not at the recessive level
    always_comb begin
        busy_cnt_s = 4'd0
            + 4'(data_out0 != IDLE_VAL) + 4'(data_out1 != IDLE_VAL)
            + 4'(data_out2 != IDLE_VAL) + 4'(data_out3 != IDLE_VAL)
            + 4'(data_out4 != IDLE_VAL) + 4'(data_out5 != IDLE_VAL)
            + 4'(data_out6 != IDLE_VAL) + 4'(data_out7 != IDLE_VAL);
    end

    a_one_lane: assert property (@(posedge clk) disable iff (!rst)
        (busy_cnt_s <= 4'd1))
        else $error("more than one lane away from idle");

    a_guard_ready: assert property (@(posedge clk) disable iff (!rst)
        (connected -> ready))
        else $error("connected while ready is low");

endmodule

// File: tb/tb_demux8_nbit.sv
module tb_demux8_nbit;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] data_in;
    logic [2:0] sel;
    logic       sel_valid;
    logic       disc;

    logic [1:0] o4 [8];
    logic [1:0] o0 [8];
    logic       rdy4, con4, rdy0, con0;
    logic [2:0] ch4, ch0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    demux8_nbit #(.N(2), .IDLE_VAL(2'b11), .GUARD_CYCLES(4)) dut4 (
        .clk(clk), .rst(rst), .data_in(data_in), .sel(sel),
        .sel_valid(sel_valid), .disc(disc),
        .data_out0(o4[0]), .data_out1(o4[1]), .data_out2(o4[2]), .data_out3(o4[3]),
        .data_out4(o4[4]), .data_out5(o4[5]), .data_out6(o4[6]), .data_out7(o4[7]),
        .ready(rdy4), .connected(con4), .active_ch(ch4)
    );

    demux8_nbit #(.N(2), .IDLE_VAL(2'b11), .GUARD_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .data_in(data_in), .sel(sel),
        .sel_valid(sel_valid), .disc(disc),
        .data_out0(o0[0]), .data_out1(o0[1]), .data_out2(o0[2]), .data_out3(o0[3]),
        .data_out4(o0[4]), .data_out5(o0[5]), .data_out6(o0[6]), .data_out7(o0[7]),
        .ready(rdy0), .connected(con0), .active_ch(ch0)
    );

    demux8_nbit_chk #(.N(2), .IDLE_VAL(2'b11)) chk4 (
        .clk(clk), .rst(rst), .ready(rdy4), .connected(con4),
        .data_out0(o4[0]), .data_out1(o4[1]), .data_out2(o4[2]), .data_out3(o4[3]),
        .data_out4(o4[4]), .data_out5(o4[5]), .data_out6(o4[6]), .data_out7(o4[7])
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; sel_valid = 1'b0; disc = 1'b0; sel = 3'd0; data_in = 2'b00;
        tick();
        tick();
        for (int i = 0; i < 8; i++) begin
            total++;
            if (o4[i] !== 2'b11) begin bad++; $display("FAIL reset_out%0d: got %b want 11", i, o4[i]); end
        end
        total++;
        if (con4 !== 1'b0 || ch4 !== 3'd0 || rdy4 !== 1'b1) begin
            bad++; $display("FAIL reset_status: con=%b ch=%0d rdy=%b want 0/0/1", con4, ch4, rdy4);
        end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_connect();
        logic [1:0] exp;
        data_in = 2'b01; sel = 3'd3; sel_valid = 1'b1;
        tick();
        sel_valid = 1'b0;
        total++;
        if (rdy4 !== 1'b0) begin bad++; $display("FAIL connect_ready_guard: got %b want 0", rdy4); end
        for (int k = 1; k <= 5; k++) begin
            tick();
            for (int i = 0; i < 8; i++) begin
                exp = (k == 5 && i == 3) ? 2'b01 : 2'b11;
                total++;
                if (o4[i] !== exp) begin bad++; $display("FAIL connect_T+%0d_out%0d: got %b want %b", k, i, o4[i], exp); end
            end
            total++;
            if (con4 !== 1'(k >= 4)) begin bad++; $display("FAIL connect_T+%0d_connected: got %b want %b", k, con4, 1'(k >= 4)); end
        end
        total++;
        if (ch4 !== 3'd3) begin bad++; $display("FAIL connect_active_ch: got %0d want 3", ch4); end
    endtask

    task automatic test_switch();
        logic [1:0] exp;
        data_in = 2'b10; sel = 3'd5; sel_valid = 1'b1;
        tick();
        sel_valid = 1'b0;
        for (int k = 0; k <= 5; k++) begin
            if (k > 0) tick();
            exp = (k == 5) ? 2'b10 : 2'b11;
            total++;
            if (o4[3] !== 2'b11 || o4[5] !== exp) begin
                bad++; $display("FAIL switch_T+%0d: out3=%b out5=%b want 11/%b", k, o4[3], o4[5], exp);
            end
            total++;
            if (con4 !== 1'(k >= 4)) begin bad++; $display("FAIL switch_T+%0d_connected: got %b want %b", k, con4, 1'(k >= 4)); end
        end
        // same-channel request: no gap
        sel = 3'd5; sel_valid = 1'b1; data_in = 2'b01;
        tick();
        sel_valid = 1'b0;
        total++;
        if (o4[5] !== 2'b01 || con4 !== 1'b1 || rdy4 !== 1'b1 || ch4 !== 3'd5) begin
            bad++; $display("FAIL same_ch: out5=%b con=%b rdy=%b ch=%0d want 01/1/1/5", o4[5], con4, rdy4, ch4);
        end
        data_in = 2'b00;
        tick();
        total++;
        if (o4[5] !== 2'b00) begin bad++; $display("FAIL same_ch_flow: got %b want 00", o4[5]); end
    endtask

    task automatic test_conflicts();
        sel = 3'd2; sel_valid = 1'b1;
        tick();
        sel = 3'd6;
        tick();
        sel_valid = 1'b0;
        total++;
        if (ch4 !== 3'd2 || rdy4 !== 1'b0) begin bad++; $display("FAIL guard_ignore: ch=%0d rdy=%b want 2/0", ch4, rdy4); end
        tick();
        tick();
        total++;
        if (con4 !== 1'b0) begin bad++; $display("FAIL guard_T+3_connected: got %b want 0", con4); end
        tick();
        total++;
        if (con4 !== 1'b1) begin bad++; $display("FAIL guard_T+4_connected: got %b want 1", con4); end
        data_in = 2'b01;
        tick();
        total++;
        if (o4[2] !== 2'b01 || o4[6] !== 2'b11) begin bad++; $display("FAIL guard_live: out2=%b out6=%b want 01/11", o4[2], o4[6]); end
        // disc and sel_valid together
        disc = 1'b1; sel_valid = 1'b1; sel = 3'd4;
        tick();
        disc = 1'b0; sel_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            total++;
            if (o4[i] !== 2'b11) begin bad++; $display("FAIL disc_win_out%0d: got %b want 11", i, o4[i]); end
        end
        total++;
        if (con4 !== 1'b0 || rdy4 !== 1'b1 || ch4 !== 3'd2) begin
            bad++; $display("FAIL disc_win_status: con=%b rdy=%b ch=%0d want 0/1/2", con4, rdy4, ch4);
        end
        tick();
        total++;
        if (con4 !== 1'b0 || o4[4] !== 2'b11) begin bad++; $display("FAIL disc_idle_hold: con=%b out4=%b want 0/11", con4, o4[4]); end
    endtask

    task automatic test_reset_mid();
        sel = 3'd1; sel_valid = 1'b1;
        tick();
        sel_valid = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        total++;
        if (con4 !== 1'b0 || ch4 !== 3'd0 || rdy4 !== 1'b1 || o4[1] !== 2'b11) begin
            bad++; $display("FAIL rst_guard: con=%b ch=%0d rdy=%b out1=%b want 0/0/1/11", con4, ch4, rdy4, o4[1]);
        end
        sel = 3'd6; sel_valid = 1'b1;
        tick();
        sel_valid = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        data_in = 2'b10;
        tick();
        total++;
        if (o4[6] !== 2'b10) begin bad++; $display("FAIL rst_pre_active: got %b want 10", o4[6]); end
        rst = 1'b0; sel_valid = 1'b1; sel = 3'd2; disc = 1'b1;
        tick();
        rst = 1'b1; sel_valid = 1'b0; disc = 1'b0;
        for (int i = 0; i < 8; i++) begin
            total++;
            if (o4[i] !== 2'b11) begin bad++; $display("FAIL rst_active_out%0d: got %b want 11", i, o4[i]); end
        end
        total++;
        if (con4 !== 1'b0 || ch4 !== 3'd0) begin bad++; $display("FAIL rst_active_status: con=%b ch=%0d want 0/0", con4, ch4); end
        tick();
        total++;
        if (rdy4 !== 1'b1 || con4 !== 1'b0) begin bad++; $display("FAIL rst_after: rdy=%b con=%b want 1/0", rdy4, con4); end
    endtask

    task automatic test_zero_guard();
        logic [1:0] exp;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        sel = 3'd7; sel_valid = 1'b1; data_in = 2'b00;
        tick();
        sel_valid = 1'b0;
        total++;
        if (rdy0 !== 1'b1 || con0 !== 1'b1 || o0[7] !== 2'b11) begin
            bad++; $display("FAIL zg_accept: rdy=%b con=%b out7=%b want 1/1/11", rdy0, con0, o0[7]);
        end
        for (int k = 1; k <= 6; k++) begin
            exp = (k % 2 == 1) ? 2'b10 : 2'b00;
            data_in = exp;
            tick();
            total++;
            if (o0[7] !== exp || rdy0 !== 1'b1) begin
                bad++; $display("FAIL zg_T+%0d: out7=%b rdy=%b want %b/1", k, o0[7], rdy0, exp);
            end
            for (int i = 0; i < 7; i++) begin
                total++;
                if (o0[i] !== 2'b11) begin bad++; $display("FAIL zg_T+%0d_out%0d: got %b want 11", k, i, o0[i]); end
            end
        end
    endtask

    task automatic test_random();
        int         st;
        int         mcnt;
        logic [2:0] mch;
        logic [1:0] mexp [8];
        logic       acc;
        int         busy4, busy0;
        st = 0; mcnt = 0; mch = 3'd0;
        for (int i = 0; i < 8; i++) mexp[i] = 2'b11;
        for (int c = 0; c < 400; c++) begin
            rst       = (c == 0) ? 1'b0 : ($urandom_range(0, 39) != 0);
            sel_valid = ($urandom_range(0, 3) == 0);
            disc      = ($urandom_range(0, 15) == 0);
            sel       = 3'($urandom_range(0, 7));
            data_in   = 2'($urandom_range(0, 3));
            if (!rst) begin
                st = 0; mcnt = 0; mch = 3'd0;
                for (int i = 0; i < 8; i++) mexp[i] = 2'b11;
            end else begin
                acc = sel_valid && (st != 1) && !disc;
                for (int i = 0; i < 8; i++) mexp[i] = 2'b11;
                if (st == 0) begin
                    if (acc) begin mch = sel; mcnt = 4; st = 1; end
                end else if (st == 1) begin
                    if (disc) st = 0;
                    else if (mcnt == 1) begin st = 2; mcnt = 0; end
                    else mcnt = mcnt - 1;
                end else begin
                    if (disc) st = 0;
                    else if (acc && sel != mch) begin mch = sel; mcnt = 4; st = 1; end
                    else mexp[mch] = data_in;
                end
            end
            tick();
            total++;
            if (rdy4 !== 1'(st != 1) || con4 !== 1'(st == 2) || ch4 !== mch) begin
                bad++; $display("FAIL rnd%0d_status: rdy=%b con=%b ch=%0d want %b/%b/%0d", c, rdy4, con4, ch4, 1'(st != 1), 1'(st == 2), mch);
            end
            for (int i = 0; i < 8; i++) begin
                total++;
                if (o4[i] !== mexp[i]) begin bad++; $display("FAIL rnd%0d_out%0d: got %b want %b", c, i, o4[i], mexp[i]); end
            end
            busy4 = 0; busy0 = 0;
            for (int i = 0; i < 8; i++) begin
                if (o4[i] !== 2'b11) busy4++;
                if (o0[i] !== 2'b11) busy0++;
            end
            total++;
            if (busy4 > 1 || busy0 > 1) begin bad++; $display("FAIL rnd%0d_onehot: busy4=%0d busy0=%0d want <=1", c, busy4, busy0); end
        end
        sel_valid = 1'b0; disc = 1'b0; rst = 1'b1;
    endtask

    initial begin
        test_reset();
        test_connect();
        test_switch();
        test_conflicts();
        test_reset_mid();
        test_zero_guard();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
